dot_score_scan: RTL

//  Reader side of the dot-eaten register bank: once per frame, snapshots the N_DOTS eaten flags and walks them serially.

---
 rtl/dot_score_scan_if.sv | 29 ++
 rtl/dot_score_scan.sv | 117 +++++++++++
 2 files changed

// File: rtl/dot_score_scan_if.sv
// Bundle between the dot-tracker/HUD side and the dot score scanner.
// The master drives the scan request and eaten flags; the slave returns results.
interface dot_score_scan_if #(
  parameter int N_DOTS  = 32,
  parameter int SCORE_W = 16,
  parameter int CNT_W   = $clog2(N_DOTS + 1)
);
  logic               frame_start;
  logic [N_DOTS-1:0]  eaten;
  logic               busy;
  logic               done;
  logic [SCORE_W-1:0] score;
  logic [CNT_W-1:0]   dots_remaining;
  logic [CNT_W-1:0]   new_eats;
  logic               eat_event;
  logic               level_clear;

  modport master (
    output frame_start, eaten,
    input  busy, done, score, dots_remaining,
    input  new_eats, eat_event, level_clear
  );

  modport slave (
    input  frame_start, eaten,
    output busy, done, score, dots_remaining,
    output new_eats, eat_event, level_clear
  );
endinterface

// File: rtl/dot_score_scan.sv
// Per-frame serial scan of the dot-eaten flags.
// Produces dots remaining, newly eaten count, saturating score, level clear.
module dot_score_scan #(
  parameter int N_DOTS     = 32,
  parameter int DOT_POINTS = 10,
  parameter int SCORE_W    = 16,
  parameter int CNT_W      = $clog2(N_DOTS + 1)
) (
  input logic             Clk,
  input logic             Reset_n,
  input logic             Clear,
  dot_score_scan_if.slave bus
);

  localparam int IDX_W = (N_DOTS > 1) ? $clog2(N_DOTS) : 1;
  localparam int SUM_W = SCORE_W + CNT_W + 8;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DOTS - 1);
  localparam logic [CNT_W-1:0] ALL_DOTS = CNT_W'(N_DOTS);
  localparam logic [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    UPDATE
  } state_t;

  state_t            state;
  logic [N_DOTS-1:0] sample;
  logic [N_DOTS-1:0] prev;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt_eaten;
  logic [CNT_W-1:0]  cnt_new;
  logic [SUM_W-1:0]  sum;

  // Wide enough that the add can never wrap before saturation.
  always_comb begin
    sum = SUM_W'(bus.score)
        + SUM_W'(cnt_new) * SUM_W'(DOT_POINTS);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state              <= IDLE;
      sample             <= '0;
      prev               <= '0;
      idx                <= '0;
      cnt_eaten          <= '0;
      cnt_new            <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.score          <= '0;
      bus.dots_remaining <= ALL_DOTS;
      bus.new_eats       <= '0;
      bus.eat_event      <= 1'b0;
      bus.level_clear    <= 1'b0;
    end else if (Clear) begin
      state              <= IDLE;
      sample             <= '0;
      prev               <= '0;
      idx                <= '0;
      cnt_eaten          <= '0;
      cnt_new            <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.score          <= '0;
      bus.dots_remaining <= ALL_DOTS;
      bus.new_eats       <= '0;
      bus.eat_event      <= 1'b0;
      bus.level_clear    <= 1'b0;
    end else begin
      bus.done      <= 1'b0;
      bus.eat_event <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            sample    <= bus.eaten;
            idx       <= '0;
            cnt_eaten <= '0;
            cnt_new   <= '0;
            bus.busy  <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          cnt_eaten <= cnt_eaten + CNT_W'(sample[idx]);
          cnt_new   <= cnt_new
                     + CNT_W'(sample[idx] & ~prev[idx]);
          if (idx == LAST_IDX) begin
            state <= UPDATE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        UPDATE: begin
          prev               <= sample;
          bus.dots_remaining <= ALL_DOTS - cnt_eaten;
          bus.new_eats       <= cnt_new;
          bus.score          <= (sum > SAT_MAX)
                                ? SAT_MAX[SCORE_W-1:0]
                                : sum[SCORE_W-1:0];
          bus.level_clear    <= (cnt_eaten == ALL_DOTS);
          bus.done           <= 1'b1;
          bus.eat_event      <= (cnt_new != '0);
          bus.busy           <= 1'b0;
          state              <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
